dbg_mem_loader: RTL and testbench

//  Host-side debug controller directly upstream of the CPU top. Accepts word-oriented

---
 rtl/dbg_mem_loader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_dbg_mem_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mem_loader.sv
// rtl/dbg_mem_loader.sv - host debug command sequencer for CPU instruction/data RAM and run control
//
// Purpose: accepts word-oriented host commands and turns them into instruction-RAM and
// data-RAM debug accesses, CPU start/quit pulses and PC readback. Memory access is
// refused (cmd_err) while the CPU is running.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_op/cmd_adr/cmd_len command fields
//   wd_valid/wd_ready/wd_data     host write-data stream for WR_I/WR_D
//   rd_valid/rd_ready/rd_data     readback stream for RD_I/RD_D/RD_PC
//   cmd_err                       pulse: memory op rejected while CPU running
//   cpu_running/cpu_start/quit_cmd/start_adr   CPU run control
//   i_ram_*                       instruction-RAM debug port (4096 words)
//   d_ram_*                       data-RAM debug port (2^DWIDTH words)
//   pc_data                       current CPU PC for RD_PC
module dbg_mem_loader #(
  parameter int DWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [29:0]       cmd_adr,
  input  logic [7:0]        cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [31:0]       wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              cmd_err,
  output logic              cpu_running,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic [29:0]       start_adr,
  output logic [11:0]       i_ram_wadr,
  output logic [11:0]       i_ram_radr,
  output logic [31:0]       i_ram_wdata,
  output logic              i_ram_wen,
  output logic              i_read_sel,
  input  logic [31:0]       i_ram_rdata,
  output logic [DWIDTH-1:0] d_ram_wadr,
  output logic [DWIDTH-1:0] d_ram_radr,
  output logic [31:0]       d_ram_wdata,
  output logic              d_ram_wen,
  output logic              d_read_sel,
  input  logic [31:0]       d_ram_rdata,
  input  logic [31:0]       pc_data
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WR_I  = 3'd1;
  localparam logic [2:0] OP_WR_D  = 3'd2;
  localparam logic [2:0] OP_RD_I  = 3'd3;
  localparam logic [2:0] OP_RD_D  = 3'd4;
  localparam logic [2:0] OP_START = 3'd5;
  localparam logic [2:0] OP_QUIT  = 3'd6;
  localparam logic [2:0] OP_RD_PC = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADR,
    S_RD_WAIT,
    S_RD_HOLD,
    S_PC_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic                is_d_q, is_d_d;       // current burst targets data RAM
  logic [7:0]          cnt_q, cnt_d;         // words remaining minus 1
  logic [11:0]         i_adr_q, i_adr_d;     // doubles as the IRAM read address
  logic [DWIDTH-1:0]   d_adr_q, d_adr_d;     // doubles as the DRAM read address
  logic [11:0]         i_wadr_q, i_wadr_d;
  logic [31:0]         i_wdata_q, i_wdata_d;
  logic                i_wen_q, i_wen_d;
  logic                i_rsel_q, i_rsel_d;
  logic [DWIDTH-1:0]   d_wadr_q, d_wadr_d;
  logic [31:0]         d_wdata_q, d_wdata_d;
  logic                d_wen_q, d_wen_d;
  logic                d_rsel_q, d_rsel_d;
  logic                rd_valid_q, rd_valid_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                cmd_err_q, cmd_err_d;
  logic                cpu_start_q, cpu_start_d;
  logic                quit_q, quit_d;
  logic                running_q, running_d;
  logic [29:0]         start_adr_q, start_adr_d;

  logic cmd_fire;
  logic wd_fire;
  logic op_is_mem;
  logic op_is_dram;
  logic op_is_rd;

  assign cmd_ready  = (state_q == S_IDLE);
  assign wd_ready   = (state_q == S_WR);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign wd_fire    = wd_valid & wd_ready;
  assign op_is_mem  = (cmd_op == OP_WR_I) || (cmd_op == OP_WR_D) ||
                      (cmd_op == OP_RD_I) || (cmd_op == OP_RD_D);
  assign op_is_dram = (cmd_op == OP_WR_D) || (cmd_op == OP_RD_D);
  assign op_is_rd   = (cmd_op == OP_RD_I) || (cmd_op == OP_RD_D);

  always_comb begin
    state_d     = state_q;
    is_d_d      = is_d_q;
    cnt_d       = cnt_q;
    i_adr_d     = i_adr_q;
    d_adr_d     = d_adr_q;
    i_wadr_d    = i_wadr_q;
    i_wdata_d   = i_wdata_q;
    i_wen_d     = 1'b0;
    i_rsel_d    = i_rsel_q;
    d_wadr_d    = d_wadr_q;
    d_wdata_d   = d_wdata_q;
    d_wen_d     = 1'b0;
    d_rsel_d    = d_rsel_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    cmd_err_d   = 1'b0;
    cpu_start_d = 1'b0;
    quit_d      = 1'b0;
    running_d   = running_q;
    start_adr_d = start_adr_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (op_is_mem) begin
            if (running_q) begin
              cmd_err_d = 1'b1;
            end else begin
              is_d_d = op_is_dram;
              cnt_d  = cmd_len;
              if (op_is_dram) d_adr_d = cmd_adr[DWIDTH-1:0];
              else            i_adr_d = cmd_adr[11:0];
              if (op_is_rd) begin
                state_d = S_RD_ADR;
                // read_sel stays up for the whole burst so the CPU side keeps the
                // RAM read port muxed to the debug address
                if (op_is_dram) d_rsel_d = 1'b1;
                else            i_rsel_d = 1'b1;
              end else begin
                state_d = S_WR;
              end
            end
          end else begin
            case (cmd_op)
              OP_START: begin
                start_adr_d = cmd_adr;
                cpu_start_d = 1'b1;
                running_d   = 1'b1;
              end
              OP_QUIT: begin
                quit_d    = 1'b1;
                running_d = 1'b0;
              end
              OP_RD_PC: begin
                rd_data_d  = pc_data;
                rd_valid_d = 1'b1;
                state_d    = S_PC_HOLD;
              end
              OP_NOP:  ;
              default: ;
            endcase
          end
        end
      end

      S_WR: begin
        if (wd_fire) begin
          if (is_d_q) begin
            d_wen_d   = 1'b1;
            d_wadr_d  = d_adr_q;
            d_wdata_d = wd_data;
            d_adr_d   = d_adr_q + 1'b1;
          end else begin
            i_wen_d   = 1'b1;
            i_wadr_d  = i_adr_q;
            i_wdata_d = wd_data;
            i_adr_d   = i_adr_q + 1'b1;
          end
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_IDLE;
        end
      end

      // Address is presented during RD_ADR; the RAM returns data one cycle later.
      S_RD_ADR: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        rd_data_d  = is_d_q ? d_ram_rdata : i_ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = S_RD_HOLD;
      end

      S_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (cnt_q == 8'd0) begin
            state_d  = S_IDLE;
            i_rsel_d = 1'b0;
            d_rsel_d = 1'b0;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            state_d = S_RD_ADR;
            if (is_d_q) d_adr_d = d_adr_q + 1'b1;
            else        i_adr_d = i_adr_q + 1'b1;
          end
        end
      end

      S_PC_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_d_q      <= 1'b0;
      cnt_q       <= 8'd0;
      i_adr_q     <= '0;
      d_adr_q     <= '0;
      i_wadr_q    <= '0;
      i_wdata_q   <= '0;
      i_wen_q     <= 1'b0;
      i_rsel_q    <= 1'b0;
      d_wadr_q    <= '0;
      d_wdata_q   <= '0;
      d_wen_q     <= 1'b0;
      d_rsel_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cmd_err_q   <= 1'b0;
      cpu_start_q <= 1'b0;
      quit_q      <= 1'b0;
      running_q   <= 1'b0;
      start_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      is_d_q      <= is_d_d;
      cnt_q       <= cnt_d;
      i_adr_q     <= i_adr_d;
      d_adr_q     <= d_adr_d;
      i_wadr_q    <= i_wadr_d;
      i_wdata_q   <= i_wdata_d;
      i_wen_q     <= i_wen_d;
      i_rsel_q    <= i_rsel_d;
      d_wadr_q    <= d_wadr_d;
      d_wdata_q   <= d_wdata_d;
      d_wen_q     <= d_wen_d;
      d_rsel_q    <= d_rsel_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cmd_err_q   <= cmd_err_d;
      cpu_start_q <= cpu_start_d;
      quit_q      <= quit_d;
      running_q   <= running_d;
      start_adr_q <= start_adr_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign cmd_err     = cmd_err_q;
  assign cpu_running = running_q;
  assign cpu_start   = cpu_start_q;
  assign quit_cmd    = quit_q;
  assign start_adr   = start_adr_q;
  assign i_ram_wadr  = i_wadr_q;
  assign i_ram_radr  = i_adr_q;
  assign i_ram_wdata = i_wdata_q;
  assign i_ram_wen   = i_wen_q;
  assign i_read_sel  = i_rsel_q;
  assign d_ram_wadr  = d_wadr_q;
  assign d_ram_radr  = d_adr_q;
  assign d_ram_wdata = d_wdata_q;
  assign d_ram_wen   = d_wen_q;
  assign d_read_sel  = d_rsel_q;

endmodule

// File: tb/tb_dbg_mem_loader.sv
// tb/tb_dbg_mem_loader.sv - directed self-checking bench for dbg_mem_loader
module tb_dbg_mem_loader;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [29:0]   cmd_adr;
  logic [7:0]    cmd_len;
  logic          wd_valid, wd_ready;
  logic [31:0]   wd_data;
  logic          rd_valid, rd_ready;
  logic [31:0]   rd_data;
  logic          cmd_err, cpu_running, cpu_start, quit_cmd;
  logic [29:0]   start_adr;
  logic [11:0]   i_ram_wadr, i_ram_radr;
  logic [31:0]   i_ram_wdata, i_ram_rdata;
  logic          i_ram_wen, i_read_sel;
  logic [DW-1:0] d_ram_wadr, d_ram_radr;
  logic [31:0]   d_ram_wdata, d_ram_rdata;
  logic          d_ram_wen, d_read_sel;
  logic [31:0]   pc_data;

  always #5 clk = ~clk;

  dbg_mem_loader #(.DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .cmd_err(cmd_err), .cpu_running(cpu_running), .cpu_start(cpu_start),
    .quit_cmd(quit_cmd), .start_adr(start_adr),
    .i_ram_wadr(i_ram_wadr), .i_ram_radr(i_ram_radr), .i_ram_wdata(i_ram_wdata),
    .i_ram_wen(i_ram_wen), .i_read_sel(i_read_sel), .i_ram_rdata(i_ram_rdata),
    .d_ram_wadr(d_ram_wadr), .d_ram_radr(d_ram_radr), .d_ram_wdata(d_ram_wdata),
    .d_ram_wen(d_ram_wen), .d_read_sel(d_read_sel), .d_ram_rdata(d_ram_rdata),
    .pc_data(pc_data)
  );

  // RAM models with one cycle read latency
  logic [31:0] imem [0:4095];
  logic [31:0] dmem [0:(1<<DW)-1];
  always @(posedge clk) begin
    if (i_ram_wen) imem[i_ram_wadr] <= i_ram_wdata;
    if (d_ram_wen) dmem[d_ram_wadr] <= d_ram_wdata;
    i_ram_rdata <= imem[i_ram_radr];
    d_ram_rdata <= dmem[d_ram_radr];
  end

  // Event logs sampled on the falling edge
  int          cyc = 0;
  int          iw_cnt = 0, dw_cnt = 0, rd_cnt = 0, ovl = 0;
  logic [11:0] iw_adr [0:63];
  logic [31:0] iw_dat [0:63];
  logic [DW-1:0] dw_adr [0:63];
  logic [31:0] rd_log [0:63];
  int          rd_cyc [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (i_ram_wen) begin
      iw_adr[iw_cnt % 64] <= i_ram_wadr;
      iw_dat[iw_cnt % 64] <= i_ram_wdata;
      iw_cnt <= iw_cnt + 1;
    end
    if (d_ram_wen) begin
      dw_adr[dw_cnt % 64] <= d_ram_wadr;
      dw_cnt <= dw_cnt + 1;
    end
    if (rd_valid && rd_ready) begin
      rd_log[rd_cnt % 64] <= rd_data;
      rd_cyc[rd_cnt % 64] <= cyc;
      rd_cnt <= rd_cnt + 1;
    end
    if ((i_ram_wen && i_read_sel) || (d_ram_wen && d_read_sel)) ovl <= ovl + 1;
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: timeout, expected event never came", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [29:0] adr, input logic [7:0] len);
    int t = 0;
    while (!cmd_ready && t < 100) begin tick(); t++; end
    if (!cmd_ready) tmo("cmd_ready_wait");
    cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr; cmd_len = len;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_adr = '0; cmd_len = '0;
  endtask

  task automatic send_wd(input logic [31:0] d);
    int t = 0;
    wd_valid = 1'b1; wd_data = d;
    while (!wd_ready && t < 100) begin tick(); t++; end
    if (!wd_ready) tmo("wd_ready_wait");
    tick();
    wd_valid = 1'b0;
  endtask

  function automatic logic any_out();
    return |{wd_ready, rd_valid, rd_data, cmd_err, cpu_running, cpu_start, quit_cmd,
             start_adr, i_ram_wadr, i_ram_radr, i_ram_wdata, i_ram_wen, i_read_sel,
             d_ram_wadr, d_ram_radr, d_ram_wdata, d_ram_wen, d_read_sel};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [29:0] adr;
    logic        err;
    logic        start;
    logic        quit;
    logic        run;
    logic [29:0] sadr;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, b2, t, bad;
    logic [31:0] d0;

    //            op    adr             err start quit run  start_adr
    tbl[0] = '{3'd0, 30'h5,          0,  0,    0,   0,   30'h0};
    tbl[1] = '{3'd6, 30'h0,          0,  0,    1,   0,   30'h0};
    tbl[2] = '{3'd5, 30'h100,        0,  1,    0,   1,   30'h100};
    tbl[3] = '{3'd2, 30'h3,          1,  0,    0,   1,   30'h100};
    tbl[4] = '{3'd3, 30'h7,          1,  0,    0,   1,   30'h100};
    tbl[5] = '{3'd5, 30'h2AAAAAAA,   0,  1,    0,   1,   30'h2AAAAAAA};
    tbl[6] = '{3'd0, 30'h1,          0,  0,    0,   1,   30'h2AAAAAAA};
    tbl[7] = '{3'd6, 30'h0,          0,  0,    1,   0,   30'h2AAAAAAA};

    cmd_valid = 0; cmd_op = 0; cmd_adr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; rd_ready = 0; pc_data = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_zero", 32'(any_out()), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_outs_zero", 32'(any_out()), 0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // WR_I burst of 4 words with a wd_valid gap
    b = iw_cnt;
    send_cmd(3'd1, 30'h10, 8'd3);
    chk("wr_wd_ready", 32'(wd_ready), 1);
    chk("wr_cmd_ready", 32'(cmd_ready), 0);
    for (int k = 0; k < 4; k++) begin
      send_wd(32'hA0 + k);
      if (k == 1) begin
        repeat (3) tick();
        chk("wr_gap_no_wen", 32'(iw_cnt - b), 2);
      end
    end
    tick(); tick();
    chk("wr_count", 32'(iw_cnt - b), 4);
    for (int k = 0; k < 4; k++) begin
      chk("wr_adr", 32'(iw_adr[(b + k) % 64]), 32'h10 + k);
      chk("wr_dat", iw_dat[(b + k) % 64], 32'hA0 + k);
    end
    chk("wr_back_idle", 32'(cmd_ready), 1);
    chk("wr_wd_ready_off", 32'(wd_ready), 0);

    // WR_D across the top of DRAM, then RD_D reading it back with wrap
    b = dw_cnt;
    send_cmd(3'd2, 30'hFFF, 8'd1);
    send_wd(32'hDEAD0FFF);
    send_wd(32'hBEEF0000);
    tick(); tick();
    chk("wrd_count", 32'(dw_cnt - b), 2);
    chk("wrd_adr0", 32'(dw_adr[b % 64]), 32'hFFF);
    chk("wrd_adr1_wrap", 32'(dw_adr[(b + 1) % 64]), 32'h000);

    b = rd_cnt;
    rd_ready = 1'b1;
    send_cmd(3'd4, 30'hFFF, 8'd1);
    chk("rdd_radr0", 32'(d_ram_radr), 32'hFFF);
    chk("rdd_read_sel", 32'(d_read_sel), 1);
    t = 0;
    while ((rd_cnt - b) < 2 && t < 50) begin tick(); t++; end
    if ((rd_cnt - b) < 2) tmo("rdd_words");
    tick();
    rd_ready = 1'b0;
    chk("rdd_count", 32'(rd_cnt - b), 2);
    chk("rdd_word0", rd_log[b % 64], 32'hDEAD0FFF);
    chk("rdd_word1", rd_log[(b + 1) % 64], 32'hBEEF0000);
    chk("rdd_throughput", 32'(rd_cyc[(b + 1) % 64] - rd_cyc[b % 64]), 3);
    chk("rdd_radr_wrapped", 32'(d_ram_radr), 32'h000);
    chk("rdd_read_sel_off", 32'(d_read_sel), 0);
    chk("rdd_idle", 32'(cmd_ready), 1);

    // RD_I single word held under rd_ready low
    send_cmd(3'd3, 30'h12, 8'd0);
    t = 0;
    while (!rd_valid && t < 20) begin tick(); t++; end
    if (!rd_valid) tmo("rdi_valid");
    d0 = rd_data;
    chk("rdi_data", rd_data, 32'hA2);
    bad = 0;
    repeat (10) begin
      tick();
      if (!rd_valid || rd_data !== d0) bad++;
    end
    chk("rdi_hold_stable", 32'(bad), 0);
    chk("rdi_read_sel", 32'(i_read_sel), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rdi_valid_drop", 32'(rd_valid), 0);
    chk("rdi_read_sel_off", 32'(i_read_sel), 0);
    chk("rdi_idle", 32'(cmd_ready), 1);

    // Run-control table
    b = iw_cnt; b2 = dw_cnt;
    for (int v = 0; v < 8; v++) begin
      wd_valid = 1'b1; wd_data = 32'h5555_0000 + v;
      send_cmd(tbl[v].op, tbl[v].adr, 8'd0);
      chk("tbl_err", 32'(cmd_err), 32'(tbl[v].err));
      chk("tbl_start", 32'(cpu_start), 32'(tbl[v].start));
      chk("tbl_quit", 32'(quit_cmd), 32'(tbl[v].quit));
      chk("tbl_running", 32'(cpu_running), 32'(tbl[v].run));
      chk("tbl_start_adr", 32'(start_adr), 32'(tbl[v].sadr));
      chk("tbl_idle", 32'(cmd_ready), 1);
      chk("tbl_no_wd", 32'(wd_ready), 0);
      tick();
      chk("tbl_pulses_clear", 32'({cmd_err, cpu_start, quit_cmd}), 0);
    end
    wd_valid = 1'b0;
    chk("tbl_no_iwen", 32'(iw_cnt - b), 0);
    chk("tbl_no_dwen", 32'(dw_cnt - b2), 0);

    // QUIT then RD_PC
    send_cmd(3'd5, 30'h40, 8'd0);
    chk("q_running", 32'(cpu_running), 1);
    send_cmd(3'd6, 30'h0, 8'd0);
    chk("q_quit_pulse", 32'(quit_cmd), 1);
    chk("q_stopped", 32'(cpu_running), 0);
    tick();
    chk("q_quit_clear", 32'(quit_cmd), 0);
    pc_data = 32'h1234;
    send_cmd(3'd7, 30'h0, 8'd0);
    chk("pc_valid", 32'(rd_valid), 1);
    chk("pc_data", rd_data, 32'h1234);
    pc_data = 32'h9999;
    tick(); tick();
    chk("pc_hold", rd_data, 32'h1234);
    chk("pc_busy", 32'(cmd_ready), 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pc_done", 32'(rd_valid), 0);
    chk("pc_idle", 32'(cmd_ready), 1);

    // Reset in the middle of a write burst
    b = iw_cnt;
    send_cmd(3'd1, 30'h20, 8'd7);
    send_wd(32'h11);
    send_wd(32'h22);
    chk("mid_wen_pending", 32'(i_ram_wen), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs_zero", 32'(any_out()), 0);
    chk("mid_rst_idle", 32'(cmd_ready), 1);
    tick(); tick();
    rst_n = 1'b1;
    b2 = iw_cnt;
    wd_valid = 1'b1; wd_data = 32'h33;
    repeat (5) tick();
    wd_valid = 1'b0;
    chk("mid_no_wen_after", 32'(iw_cnt - b2), 0);
    chk("mid_aborted_word", 32'(iw_cnt - b), 1);
    chk("mid_idle_after", 32'(cmd_ready), 1);
    chk("mid_wd_ready_off", 32'(wd_ready), 0);
    chk("mid_start_adr_clr", 32'(start_adr), 0);

    chk("no_wen_rsel_overlap", 32'(ovl), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
